// File: rtl/jk_driver.sv
// jk_driver: drives an external JK flop toward a requested state and checks it.
//
// Accepts one target bit per transaction (valid/ready), issues a single-cycle
// enable with J/K chosen from the target and an internal model of the flop,
// waits SETTLE cycles for the flop to settle, then compares its Q feedback to
// the target. A disagreement pulses mismatch, bumps a saturating error count
// and resyncs the model to the observed Q.
//
// Ports:
//   clk       rising-edge clock
//   clear     synchronous active-high reset
//   in_valid  upstream offers a target bit
//   in_bit    desired next state of the driven flop
//   in_ready  block is idle and will accept in_bit this cycle
//   j, k      J/K inputs to the driven flop (registered)
//   enable    enable to the driven flop, high for exactly one cycle per transfer
//   jk_fb     Q of the driven flop
//   mismatch  one-cycle pulse after a failed compare (registered)
//   err_count saturating mismatch count (registered)
//   model_q   internal model of the flop state (registered)
module jk_driver #(
  parameter int SETTLE     = 1,
  parameter int USE_TOGGLE = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             j,
  output logic             k,
  output logic             enable,
  input  logic             jk_fb,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             model_q
);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT, CHECK} state_t;

  // Terminal value of the wait counter; unused when SETTLE is 0.
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

  state_t     state_q, state_d;
  logic       target_q;
  logic [3:0] wcnt_q;
  logic       j_d, k_d, en_d, mis_d;

  assign in_ready = (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    j_d     = 1'b0;
    k_d     = 1'b0;
    en_d    = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = DRIVE;
          // J/K/enable are registered, so they are decided on the accept edge
          // and appear exactly during the DRIVE cycle.
          en_d = 1'b1;
          if (in_bit != model_q) begin
            if (USE_TOGGLE != 0) begin
              j_d = 1'b1;
              k_d = 1'b1;
            end else begin
              j_d = in_bit;
              k_d = ~in_bit;
            end
          end
        end
      end
      DRIVE: state_d = (SETTLE > 0) ? WAIT : CHECK;
      WAIT:  if (wcnt_q == SETTLE_LAST) state_d = CHECK;
      CHECK: begin
        state_d = IDLE;
        mis_d   = (jk_fb != target_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      target_q  <= 1'b0;
      wcnt_q    <= '0;
      j         <= 1'b0;
      k         <= 1'b0;
      enable    <= 1'b0;
      mismatch  <= 1'b0;
      err_count <= '0;
      model_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      j        <= j_d;
      k        <= k_d;
      enable   <= en_d;
      mismatch <= mis_d;
      if (state_q == IDLE && in_valid) target_q <= in_bit;
      if (state_q == DRIVE) begin
        model_q <= target_q;
        wcnt_q  <= '0;
      end
      if (state_q == WAIT) wcnt_q <= wcnt_q + 4'd1;
      // Failed compare: trust the real flop and count the event.
      if (mis_d) begin
        model_q <= jk_fb;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_driver.sv
// Bench for jk_driver: dut 0 is SETTLE=1/toggle, dut 1 is SETTLE=0/set-reset.
// Each driven flop is a behavioural JK model that can be forced stuck.
module tb_jk_driver;

  logic       clk;
  logic       clear    [2];
  logic       in_valid [2];
  logic       in_bit   [2];
  logic       in_ready [2];
  logic       j        [2];
  logic       k        [2];
  logic       en       [2];
  logic       mis      [2];
  logic       mq       [2];
  logic [7:0] err      [2];
  logic       fq       [2];
  logic       tie_en   [2];
  logic       tie_v    [2];

  int checks = 0;
  int errors = 0;
  int tcyc   = 0;

  typedef struct {
    int   d;
    logic b, tie, tv, ej, ek, emq, emis;
    int   eerr;
  } vec_t;

  typedef struct {
    int   d;
    logic j, k;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[10];

  jk_driver #(.SETTLE(1), .USE_TOGGLE(1), .CNT_W(8)) u0 (
    .clk(clk), .clear(clear[0]), .in_valid(in_valid[0]), .in_bit(in_bit[0]),
    .in_ready(in_ready[0]), .j(j[0]), .k(k[0]), .enable(en[0]), .jk_fb(fq[0]),
    .mismatch(mis[0]), .err_count(err[0]), .model_q(mq[0]));

  jk_driver #(.SETTLE(0), .USE_TOGGLE(0), .CNT_W(8)) u1 (
    .clk(clk), .clear(clear[1]), .in_valid(in_valid[1]), .in_bit(in_bit[1]),
    .in_ready(in_ready[1]), .j(j[1]), .k(k[1]), .enable(en[1]), .jk_fb(fq[1]),
    .mismatch(mis[1]), .err_count(err[1]), .model_q(mq[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tcyc <= tcyc + 1;

  // Behavioural driven flops (optionally stuck at tie_v).
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (clear[d])       fq[d] <= 1'b0;
      else if (tie_en[d]) fq[d] <= tie_v[d];
      else if (en[d])     fq[d] <= (j[d] && k[d]) ? ~fq[d] : j[d] ? 1'b1 : k[d] ? 1'b0 : fq[d];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at cycle %0d", nm, act, exp, tcyc);
    end
  endtask

  // Scoreboard sink: every enable cycle consumes one expected J/K record.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (en[d] === 1'b1) begin
        if (sbq.size() == 0) chk("sb_unexpected_enable", 32'(d), 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_dut", 32'(d), 32'(e.d));
          chk("sb_j", {31'b0, j[d]}, {31'b0, e.j});
          chk("sb_k", {31'b0, k[d]}, {31'b0, e.k});
          chk("sb_ready_busy", {31'b0, in_ready[d]}, 32'd0);
        end
      end
    end
  end

  task automatic wait_ready(input int d);
    int n = 0;
    while (in_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'b0, in_ready[d]}, 32'd1);
  endtask

  // One full transaction; called at a negedge.
  task automatic do_xfer(input vec_t v);
    int s = (v.d == 0) ? 1 : 0;
    tie_en[v.d] = v.tie;
    tie_v[v.d]  = v.tv;
    wait_ready(v.d);
    in_valid[v.d] = 1'b1;
    in_bit[v.d]   = v.b;
    sbq.push_back('{d: v.d, j: v.ej, k: v.ek});
    @(posedge clk);
    #1 in_valid[v.d] = 1'b0;
    @(negedge clk);                 // DRIVE
    repeat (s) @(negedge clk);      // WAIT
    @(negedge clk);                 // CHECK
    chk("check_ready", {31'b0, in_ready[v.d]}, 32'd0);
    chk("check_mq_target", {31'b0, mq[v.d]}, {31'b0, v.b});
    chk("check_nomis", {31'b0, mis[v.d]}, 32'd0);
    @(negedge clk);                 // IDLE with compare result
    chk("idle_ready", {31'b0, in_ready[v.d]}, 32'd1);
    chk("mismatch", {31'b0, mis[v.d]}, {31'b0, v.emis});
    chk("err_count", {24'b0, err[v.d]}, 32'(v.eerr));
    chk("model_q", {31'b0, mq[v.d]}, {31'b0, v.emq});
    tie_en[v.d] = 1'b0;
    @(negedge clk);
    chk("mismatch_one_cycle", {31'b0, mis[v.d]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", tcyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int last;
    vec_t sv;
    //       d  b  tie tv  j  k  mq mis err
    vt[0] = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
    vt[1] = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    vt[2] = '{0, 0, 0, 0, 1, 1, 0, 0, 0};
    vt[3] = '{0, 1, 1, 0, 1, 1, 0, 1, 1};
    vt[4] = '{0, 0, 1, 1, 0, 0, 1, 1, 2};
    vt[5] = '{0, 0, 0, 0, 1, 1, 0, 0, 2};
    vt[6] = '{1, 1, 0, 0, 1, 0, 1, 0, 0};
    vt[7] = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    vt[8] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[9] = '{1, 1, 1, 0, 1, 0, 0, 1, 1};

    for (int d = 0; d < 2; d++) begin
      clear[d] = 1'b1; in_valid[d] = 1'b0; in_bit[d] = 1'b0;
      tie_en[d] = 1'b0; tie_v[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear[0] = 1'b0; clear[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'b0, in_ready[d]}, 32'd1);
      chk("rst_err", {24'b0, err[d]}, 32'd0);
      chk("rst_mq", {31'b0, mq[d]}, 32'd0);
      chk("rst_jke", {29'b0, j[d], k[d], en[d]}, 32'd0);
      chk("rst_mis", {31'b0, mis[d]}, 32'd0);
    end

    for (int i = 0; i < 10; i++) do_xfer(vt[i]);

    // Saturation: stuck-at-0 flop, 300 failed sets on dut 0 (count starts at 2).
    for (int i = 0; i < 300; i++) begin
      sv = '{0, 1, 1, 0, 1, 1, 0, 1, ((i + 3) > 255) ? 255 : (i + 3)};
      do_xfer(sv);
    end
    chk("sat_hold", {24'b0, err[0]}, 32'd255);

    // Continuous valid with alternating bits: one accept per 3+SETTLE cycles.
    last = 0;
    in_valid[0] = 1'b1;
    in_bit[0]   = 1'b1;
    for (int n = 0; n < 4; n++) begin
      wait_ready(0);
      sbq.push_back('{d: 0, j: 1'b1, k: 1'b1});
      if (n > 0) chk("stream_gap", 32'(tcyc - last), 32'd4);
      last = tcyc;
      @(posedge clk);
      #1;
      if (n == 3) in_valid[0] = 1'b0;
      else        in_bit[0]   = ~in_bit[0];
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("stream_mq", {31'b0, mq[0]}, 32'd0);
    chk("stream_sb_drained", 32'(sbq.size()), 32'd0);
    chk("stream_err", {24'b0, err[0]}, 32'd255);

    // Clear during WAIT aborts the transfer without a mismatch.
    wait_ready(0);
    in_valid[0] = 1'b1;
    in_bit[0]   = 1'b1;
    sbq.push_back('{d: 0, j: 1'b1, k: 1'b1});
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    @(negedge clk);                 // DRIVE
    @(negedge clk);                 // WAIT
    clear[0] = 1'b1;
    @(posedge clk);
    #1 clear[0] = 1'b0;
    @(negedge clk);
    chk("clr_ready", {31'b0, in_ready[0]}, 32'd1);
    chk("clr_err", {24'b0, err[0]}, 32'd0);
    chk("clr_mq", {31'b0, mq[0]}, 32'd0);
    chk("clr_jke", {29'b0, j[0], k[0], en[0]}, 32'd0);
    for (int n = 0; n < 4; n++) begin
      chk("clr_nomis", {31'b0, mis[0]}, 32'd0);
      chk("clr_err_hold", {24'b0, err[0]}, 32'd0);
      @(negedge clk);
    end
    chk("final_sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_driver.md
JK_DRIVER -- requirements
Module: jk_driver

Interface
REQ-001 SHALL expose parameter SETTLE, default 1: number of wait cycles between the flop's capture edge and the feedback compare (legal 0..15).
REQ-002 SHALL expose parameter USE_TOGGLE, default 1: 1 = drive a state change as J=K=1 (toggle); 0 = drive it as explicit set/reset.
REQ-003 SHALL expose parameter CNT_W, default 8: width of the mismatch counter.
REQ-004 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-005 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  upstream offers a target bit.
REQ-007 SHALL have port in_bit  input  1  desired next state of the driven JK flop.
REQ-008 SHALL have port in_ready  output  1  block can accept a target bit this cycle.
REQ-009 SHALL have port j  output  1  J input to the driven flop.
REQ-010 SHALL have port k  output  1  K input to the driven flop.
REQ-011 SHALL have port enable  output  1  enable to the driven flop.
REQ-012 SHALL have port jk_fb  input  1  Q output fed back from the driven flop.
REQ-013 SHALL have port mismatch  output  1  one-cycle pulse when feedback differs from target.
REQ-014 SHALL have port err_count  output  CNT_W  saturating count of mismatches.
REQ-015 SHALL have port model_q  output  1  internal model of the flop state.

Function
REQ-016 SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK.
REQ-017 IDLE: in_ready=1; a transfer occurs on a rising edge with in_valid=1 and in_ready=1; in_bit is latched as target; next state DRIVE.
REQ-018 in_ready SHALL be 0 in DRIVE, WAIT and CHECK; in_valid there is ignored and no data is latched.
REQ-019 DRIVE lasts exactly one cycle with enable=1 and j/k from REQ-020..022; next state WAIT if SETTLE>0, else CHECK.
REQ-020 target==model_q: j=0, k=0 (hold).
REQ-021 target!=model_q with USE_TOGGLE=1: j=1, k=1.
REQ-022 target!=model_q with USE_TOGGLE=0: target=1 gives j=1,k=0; target=0 gives j=0,k=1.
REQ-023 Outside DRIVE, j, k and enable SHALL all be 0.
REQ-024 At the DRIVE->next edge model_q SHALL take the value target.
REQ-025 WAIT SHALL last exactly SETTLE cycles, counted by an internal counter, then go to CHECK.
REQ-026 CHECK lasts one cycle, compares jk_fb with target, and returns to IDLE.
REQ-027 If jk_fb!=target in CHECK: mismatch=1 for the following cycle only, err_count increments, and model_q is loaded with jk_fb (resync).
REQ-028 err_count SHALL saturate at all-ones with no wrap; mismatch still pulses when saturated.
REQ-029 Latency: accept edge E0, enable high in the cycle after E0, compare in cycle E0+2+SETTLE, next accept no earlier than edge E0+3+SETTLE.
REQ-030 mismatch, err_count, model_q, j, k and enable SHALL be registered outputs (glitch-free).

Reset
REQ-031 With clear=1 at a rising edge, the FSM SHALL go to IDLE, model_q=0, err_count=0, mismatch=0, the wait counter=0, and j=k=enable=0.
REQ-032 clear SHALL take priority over every other event, including an in-flight DRIVE/WAIT/CHECK; the aborted transfer SHALL produce no mismatch and no count.
REQ-033 in_ready SHALL be 1 in the first cycle after clear deasserts.

Verification
REQ-034 Reset, SETTLE=1, USE_TOGGLE=1; send 1 with jk_fb following a model flop -> j=k=1, enable high for 1 cycle, model_q=1, no mismatch, in_ready returns to 1 at E0+4.
REQ-035 After REQ-034, send 1 again -> j=k=0, enable=1 for one cycle, model_q stays 1.
REQ-036 USE_TOGGLE=0, from model_q=1, send 0 -> j=0, k=1 during DRIVE.
REQ-037 Tie jk_fb=0 and send 1 -> mismatch pulses once in the cycle after CHECK, err_count=1, model_q=0; repeat 300 times with CNT_W=8 -> err_count holds at 255.
REQ-038 Hold in_valid=1 continuously with alternating bits -> transfers accepted only in IDLE, one every 3+SETTLE cycles, none lost or duplicated.
REQ-039 Assert clear during WAIT -> next cycle IDLE, err_count=0, model_q=0, j=k=enable=0, no mismatch pulse.
